rom_burst_arbiter: RTL and testbench
====================================

Name: rom_burst_arbiter

Overview:
Shares one 16x8 combinational lookup ROM between NUM_REQ requesters. Each requester posts a burst request (start address, length). The block grants requests round-robin and drives the ROM address. It returns the read bytes on one shared, registered, tagged output stream with valid/ready backpressure. It sits between client engines and the ROM instance; the ROM itself stays purely combinational.

Parameters:
NUM_REQ, 2, number of requesters (supported 2..4)
ADDR_W, 4, ROM address width; burst length field uses the same width
DATA_W, 8, ROM data width
ID_W, 1, requester tag width (clog2(NUM_REQ), minimum 1)

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_addr  in  NUM_REQ*ADDR_W  start addresses; requester i at bits [i*ADDR_W +: ADDR_W]
req_len  in  NUM_REQ*ADDR_W  burst length minus 1 (0 = 1 beat, 15 = 16 beats)
rom_addr  out  ADDR_W  address to ROM
rom_data  in  DATA_W  combinational ROM data for rom_addr
rd_valid  out  1  output beat valid
rd_ready  in  1  output beat accept
rd_data  out  DATA_W  output byte
rd_id  out  ID_W  index of the owning requester
rd_last  out  1  final beat of the burst
busy  out  1  high in BURST state

Behaviour:
- Clock, reset, handshake
  - One clock, clk. Reset rst is synchronous and active-high.
  - Handshakes complete on a rising edge with valid&ready both high.
- Reset values
  - State IDLE; req_ready 0; rom_addr 0; rd_valid 0; rd_data 0; rd_id 0; rd_last 0; busy 0.
  - Round-robin pointer 0; beat counter 0.
- States: IDLE and BURST.
- IDLE
  - req_ready is combinational. It is one-hot on the first asserted req_valid, searching from the pointer upward with wrap. It is 0 if no req_valid is asserted.
  - On an accept edge from requester g: latch addr and len, set cur_id = g, set pointer = (g+1) mod NUM_REQ, go to BURST.
  - IDLE may accept while a previous burst's last beat still sits unaccepted in the output register.
- BURST
  - req_ready = 0 and busy = 1.
  - rom_addr = current address. In IDLE, rom_addr holds its last value.
  - Load condition: !rd_valid || rd_ready.
  - On a load edge: rd_data = rom_data, rd_id = cur_id, rd_valid = 1, rd_last = (count == len). Then address = address + 1 mod 16 (0xF wraps to 0x0) and count = count + 1.
  - When the loaded beat is the last one, go to IDLE.
  - If the load condition is false, address, count and the output register hold. Data is stable under backpressure.
- Output register
  - On an edge with rd_valid & rd_ready and no new load, rd_valid goes to 0. rd_last goes to 0 with it.
- Latency
  - Accept at edge T. First beat is visible after edge T+1.
  - With rd_ready held high: one beat per cycle, len+1 consecutive beats, no bubbles within a burst.
  - Back-to-back bursts: one idle cycle on the output between bursts (the IDLE accept cycle).
- Fairness
  - A requester holding req_valid is granted within NUM_REQ grant decisions.
  - Requests are not preemptible; a burst always runs to its last beat.
- Stability
  - Requester inputs need to be stable only during the accept cycle.
  - req_valid dropped without acceptance is legal and is simply ignored.
- Reset mid-burst
  - Abort immediately. All outputs take reset values; the partial burst is dropped and no rd_last is issued.

Decomposition:
- Package rom_ctrl_pkg holds:
  - ADDR_W and DATA_W defaults.
  - State enum (IDLE, BURST).
  - Helper to slice flattened request fields.
- Sub-module rr_arbiter (parameter NUM_REQ): combinational one-hot grant from req_valid and pointer, plus registered pointer update on accept.
- The datapath, counter and output register stay in rom_burst_arbiter.
- The bench instantiates the ROM alongside the block.

Test Plan:
- Single burst: req0 addr=0x2 len=3, rd_ready=1 -> bytes 0x22,0x33,0x44,0x55 on four consecutive cycles, rd_id=0, rd_last only on 0x55, busy falls afterwards.
- Wrap: req1 addr=0xE len=2 -> 0xEE,0xFF,0x00 with rd_id=1; rd_last on 0x00.
- Round-robin: both req_valid held, each len=0, addr0=0x1, addr1=0x9 -> grants alternate 0,1,0,1; output 0x11,0x99,0x11,0x99 with matching rd_id; no requester granted twice in a row.
- Backpressure: addr=0x5 len=2, rd_ready low for 3 cycles after the first beat -> rd_data holds 0x55 with rd_valid high; then 0x66,0x77 follow; no beat is lost or duplicated.
- Max length: addr=0x0 len=15 -> all 16 bytes 0x00..0xFF in order, single rd_last on 0xFF.
- Reset mid-burst: rst pulsed on the 3rd beat of addr=0x4 len=7 -> next cycle rd_valid=0, busy=0, pointer=0. A new req1 request is then served normally.

Source files
------------

// File: rtl/rom_ctrl_pkg.sv
// Shared types and helpers for the ROM burst arbiter.
// Holds the default widths, the FSM state enum and the request-field slicer.
package rom_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned MAX_REQ    = 4;
    localparam int unsigned FLAT_W     = MAX_REQ * ADDR_W_DEF;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Pull requester idx's field out of a flattened {reqN-1, ..., req0} vector.
    function automatic logic [ADDR_W_DEF-1:0] field_at(input logic [FLAT_W-1:0] flat,
                                                       input int unsigned      idx);
        return ADDR_W_DEF'(flat >> (idx * ADDR_W_DEF));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a rotating pointer.
// The pointer moves to one past the winner on every accepted grant.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [ID_W-1:0]    grant_id_c,
    output logic               accept_c
);

    logic [ID_W-1:0] ptr_q;
    int unsigned     idx;
    logic            found;

    // First asserted request at or after the pointer, wrapping around.
    always_comb begin
        grant_c    = '0;
        grant_id_c = '0;
        found      = 1'b0;
        idx        = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(ptr_q) + k) % NUM_REQ;
            if (en && !found && req[ID_W'(idx)]) begin
                grant_c[ID_W'(idx)] = 1'b1;
                grant_id_c          = ID_W'(idx);
                found               = 1'b1;
            end
        end
        accept_c = found;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (accept_c) begin
            if (grant_id_c == ID_W'(NUM_REQ - 1)) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= grant_id_c + ID_W'(1);
            end
        end
    end

endmodule

// File: rtl/rom_burst_arbiter.sv
// Shares one combinational ROM between NUM_REQ burst requesters and streams
// the bytes out on a single registered, tagged valid/ready channel.
module rom_burst_arbiter
    import rom_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_len,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [DATA_W-1:0]         rd_data,
    output logic [ID_W-1:0]           rd_id,
    output logic                      rd_last,
    output logic                      busy
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic                rd_valid_d, rd_last_d;
    logic [DATA_W-1:0]   rd_data_d;
    logic [ID_W-1:0]     rd_id_d;

    logic [NUM_REQ-1:0]  grant_c;
    logic [ID_W-1:0]     grant_id_c;
    logic                accept_c;
    logic                load_c;
    logic [FLAT_W-1:0]   addr_flat_c, len_flat_c;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .en         (state_q == IDLE),
        .req        (req_valid),
        .grant_c    (grant_c),
        .grant_id_c (grant_id_c),
        .accept_c   (accept_c)
    );

    assign req_ready   = grant_c;
    assign rom_addr    = addr_q;
    assign busy        = (state_q == BURST);
    assign addr_flat_c = FLAT_W'(req_addr);
    assign len_flat_c  = FLAT_W'(req_len);
    // A new beat may enter the output register when it is empty or draining.
    assign load_c      = (state_q == BURST) && (!rd_valid || rd_ready);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        id_d       = id_q;
        rd_valid_d = rd_valid;
        rd_data_d  = rd_data;
        rd_id_d    = rd_id;
        rd_last_d  = rd_last;

        if (rd_valid && rd_ready) begin
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    addr_d  = ADDR_W'(field_at(addr_flat_c, 32'(grant_id_c)));
                    len_d   = ADDR_W'(field_at(len_flat_c, 32'(grant_id_c)));
                    cnt_d   = '0;
                    id_d    = grant_id_c;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (load_c) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = rom_data;
                    rd_id_d    = id_q;
                    rd_last_d  = (cnt_q == len_q);
                    addr_d     = addr_q + ADDR_W'(1);
                    cnt_d      = cnt_q + ADDR_W'(1);
                    if (cnt_q == len_q) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset drops any partial burst: no trailing beat and no rd_last.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            id_q     <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_id    <= '0;
            rd_last  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
            rd_valid <= rd_valid_d;
            rd_data  <= rd_data_d;
            rd_id    <= rd_id_d;
            rd_last  <= rd_last_d;
        end
    end

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Bench for rom_burst_arbiter: ROM holds byte a*17 at address a; a transaction-level
// model predicts grants and beats, a monitor pops the scoreboard on each output handshake.
module tb_rom_burst_arbiter;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ID_W    = 1;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*ADDR_W-1:0] req_len;
    logic [ADDR_W-1:0]         rom_addr;
    logic [DATA_W-1:0]         rom_data;
    logic                      rd_valid;
    logic                      rd_ready;
    logic [DATA_W-1:0]         rd_data;
    logic [ID_W-1:0]           rd_id;
    logic                      rd_last;
    logic                      busy;

    logic [DATA_W-1:0] rom [16];
    logic              rand_ready;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [ID_W-1:0]   id;
        logic              last;
    } beat_t;

    beat_t q[$];
    int    errors = 0;
    int    checks = 0;

    int ptr_m  = 0;
    bit busy_m = 0;
    bit full_m = 0;
    int left_m = 0;
    bit just_rst = 0;

    always #5 clk = ~clk;

    initial for (int i = 0; i < 16; i++) rom[i] = DATA_W'(i * 17);
    assign rom_data = rom[rom_addr];

    rom_burst_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .ID_W    (ID_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_id     (rd_id),
        .rd_last   (rd_last),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: grants, burst occupancy and the one-deep output slot.
    always @(negedge clk) begin
        logic [NUM_REQ-1:0] exp_g;
        int g, idx, ad, ln;
        bit load;
        beat_t b;
        if (rst) begin
            ptr_m = 0; busy_m = 0; full_m = 0; left_m = 0;
            q.delete();
            just_rst = 1;
        end else begin
            if (just_rst) begin
                chk("reset_rd_data", 32'(rd_data), 32'h0);
                chk("reset_rd_id", 32'(rd_id), 32'h0);
                chk("reset_rd_last", 32'(rd_last), 32'h0);
                chk("reset_rom_addr", 32'(rom_addr), 32'h0);
                just_rst = 0;
            end
            chk("busy", 32'(busy), 32'(busy_m));
            chk("rd_valid", 32'(rd_valid), 32'(full_m));
            exp_g = '0;
            g = -1;
            if (!busy_m) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = (ptr_m + k) % NUM_REQ;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            if (g >= 0) exp_g[g] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_g));

            load = busy_m && (!full_m || rd_ready);
            if (full_m && rd_ready) full_m = 0;
            if (load) begin
                full_m = 1;
                left_m--;
                if (left_m == 0) busy_m = 0;
            end
            if (g >= 0) begin
                ad = int'(req_addr[g*ADDR_W +: ADDR_W]);
                ln = int'(req_len[g*ADDR_W +: ADDR_W]);
                for (int j = 0; j <= ln; j++) begin
                    b.data = DATA_W'(((ad + j) % 16) * 17);
                    b.id   = ID_W'(g);
                    b.last = (j == ln);
                    q.push_back(b);
                end
                ptr_m  = (g + 1) % NUM_REQ;
                busy_m = 1;
                left_m = ln + 1;
            end
        end
    end

    // Monitor: every completed output handshake must match the scoreboard head.
    always @(negedge clk) begin
        beat_t b;
        if (!rst && rd_valid === 1'b1 && rd_ready === 1'b1) begin
            chk("beat_expected", 32'(q.size() != 0), 32'h1);
            if (q.size() != 0) begin
                b = q.pop_front();
                chk("rd_data", 32'(rd_data), 32'(b.data));
                chk("rd_id", 32'(rd_id), 32'(b.id));
                chk("rd_last", 32'(rd_last), 32'(b.last));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) rd_ready = ($urandom_range(0, 3) != 0);
    end

    // Post requests on the masked requesters; each drops valid after reps accepts.
    task automatic issue(input logic [NUM_REQ-1:0] mask, input logic [NUM_REQ*ADDR_W-1:0] a,
                         input logic [NUM_REQ*ADDR_W-1:0] l, input int reps);
        int cnt [NUM_REQ];
        logic [NUM_REQ-1:0] pend, hit;
        int budget;
        for (int i = 0; i < NUM_REQ; i++) cnt[i] = 0;
        @(posedge clk); #1;
        req_addr  = a;
        req_len   = l;
        req_valid = mask;
        pend      = mask;
        budget    = 0;
        while (pend != '0 && budget < 500) begin
            @(negedge clk);
            budget++;
            hit = req_ready & pend;
            @(posedge clk); #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (hit[i]) begin
                    cnt[i]++;
                    if (cnt[i] == reps) pend[i] = 1'b0;
                end
            end
            req_valid = pend;
        end
        req_valid = '0;
        chk("accept_timeout", 32'(pend), 32'h0);
    endtask

    task automatic drain();
        int n = 0;
        while ((busy_m || full_m || q.size() != 0) && n < 400) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk); #1;
        chk("drain_timeout", 32'(busy_m || full_m || q.size() != 0), 32'h0);
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        req_valid  = '0;
        req_addr   = '0;
        req_len    = '0;
        rd_ready   = 1'b1;
        rand_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        issue(2'b01, {4'h0, 4'h2}, {4'h0, 4'h3}, 1);
        drain();
        issue(2'b10, {4'hE, 4'h0}, {4'h2, 4'h0}, 1);
        drain();
        issue(2'b11, {4'h9, 4'h1}, {4'h0, 4'h0}, 2);
        drain();

        // Stall the first beat for three cycles and confirm it is held.
        issue(2'b01, {4'h0, 4'h5}, {4'h0, 4'h2}, 1);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (rd_valid !== 1'b1 && n < 20);
        chk("bp_first_beat", 32'(rd_valid), 32'h1);
        rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 32'(rd_valid), 32'h1);
            chk("bp_hold_data", 32'(rd_data), 32'h55);
        end
        rd_ready = 1'b1;
        drain();

        issue(2'b01, {4'h0, 4'h0}, {4'h0, 4'hF}, 1);
        drain();

        // Reset while the third beat of an 8-beat burst is on the output.
        issue(2'b01, {4'h0, 4'h4}, {4'h0, 4'h7}, 1);
        n = 0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            @(posedge clk); #1;
            if (rd_valid === 1'b1) n++;
        end
        chk("reset_third_beat", 32'(n), 32'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_rd_valid", 32'(rd_valid), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        issue(2'b11, {4'h7, 4'h3}, {4'h0, 4'h1}, 1);
        drain();
        issue(2'b10, {4'hA, 4'h0}, {4'h1, 4'h0}, 1);
        drain();

        rand_ready = 1'b1;
        for (int it = 0; it < 40; it++) begin
            issue(NUM_REQ'($urandom_range(1, 3)),
                  (NUM_REQ*ADDR_W)'($urandom),
                  {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))},
                  $urandom_range(1, 2));
        end
        rand_ready = 1'b0;
        @(posedge clk); #2;
        rd_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
